fpmul_issue_ctrl: RTL and testbench

Operand sequencer and result collector for the registered floating-point multiplier wrapper (operand flops, control register, `fpmul`, output and flag flops). Accepts operand/control triples over a valid/ready request channel, drives them onto the wrapper's `A`/`B`/`control` inputs, and tracks each operation through the wrapper's fixed pipeline. Samples `Out`/`flagout` at the correct cycle, buffers results in order in a small FIFO, and returns them on a valid/ready result channel. Credit-based issue guarantees that no result is ever dropped.

---
 rtl/fpmul_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_fpmul_issue_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_issue_ctrl.sv
// Operand sequencer and in-order result collector for the registered fpmul wrapper.
// Credit-based issue keeps (in flight + buffered) <= DEPTH, so every capture finds room.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef WCONTROL
`define WCONTROL 3
`endif
`ifndef WFLAG
`define WFLAG 5
`endif

module fpmul_issue_ctrl #(
    parameter int WIDTH    = `WIDTH,
    parameter int WCONTROL = `WCONTROL,
    parameter int WFLAG    = `WFLAG,
    parameter int LATENCY  = 2,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [WCONTROL-1:0] in_control,
    output logic [WIDTH-1:0]    mul_a,
    output logic [WIDTH-1:0]    mul_b,
    output logic [WCONTROL-1:0] mul_control,
    input  logic [WIDTH-1:0]    mul_out,
    input  logic [WFLAG-1:0]    mul_flags,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [WIDTH-1:0]    res_data,
    output logic [WFLAG-1:0]    res_flags,
    output logic                busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = WIDTH + WFLAG;

    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CONE_C  = CW'(1'b1);
    localparam logic [PW-1:0] PONE_C  = PW'(1'b1);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [LATENCY:0] tag_r;
    logic [LATENCY:0] tag_s;
    logic [CW-1:0]    inflight_r;
    logic [CW-1:0]    inflight_s;
    logic [CW-1:0]    fifo_count_r;
    logic [CW-1:0]    fifo_count_s;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    wr_ptr_s;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    rd_ptr_s;
    logic [EW-1:0]    mem_r [DEPTH];
    logic [EW-1:0]    head_s;
    logic [CW:0]      used_s;
    logic             accept_s;
    logic             capture_s;
    logic             pop_s;
    logic             fifo_nempty_s;

    // Handshake decode; the ready side depends on registered credits only.
    always_comb begin
        used_s        = {1'b0, inflight_r} + {1'b0, fifo_count_r};
        fifo_nempty_s = (fifo_count_r != {CW{1'b0}});
        accept_s      = in_valid && (used_s < DEPTH_C);
        capture_s     = tag_r[LATENCY];
        pop_s         = fifo_nempty_s && res_ready;
        head_s        = mem_r[rd_ptr_r];
    end

    assign in_ready  = (used_s < DEPTH_C);
    assign res_valid = fifo_nempty_s;
    assign res_data  = fifo_nempty_s ? head_s[EW-1:WFLAG] : {WIDTH{1'b0}};
    assign res_flags = fifo_nempty_s ? head_s[WFLAG-1:0] : {WFLAG{1'b0}};
    assign busy      = (inflight_r != {CW{1'b0}}) || fifo_nempty_s;

    // Next-state for the tag pipe, credit counters and FIFO pointers.
    always_comb begin
        tag_s    = tag_r << 1'b1;
        tag_s[0] = accept_s;

        case ({accept_s, capture_s})
            2'b10:   inflight_s = inflight_r + CONE_C;
            2'b01:   inflight_s = inflight_r - CONE_C;
            default: inflight_s = inflight_r;
        endcase

        case ({capture_s, pop_s})
            2'b10:   fifo_count_s = fifo_count_r + CONE_C;
            2'b01:   fifo_count_s = fifo_count_r - CONE_C;
            default: fifo_count_s = fifo_count_r;
        endcase

        // Explicit wrap so non-power-of-two pointer widths (DEPTH=1) still count mod DEPTH.
        if (capture_s) begin
            wr_ptr_s = (wr_ptr_r == LAST_C) ? {PW{1'b0}} : wr_ptr_r + PONE_C;
        end else begin
            wr_ptr_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_s = (rd_ptr_r == LAST_C) ? {PW{1'b0}} : rd_ptr_r + PONE_C;
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
    end

    // Control state and wrapper operand registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_r        <= {(LATENCY + 1){1'b0}};
            inflight_r   <= {CW{1'b0}};
            fifo_count_r <= {CW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            mul_a        <= {WIDTH{1'b0}};
            mul_b        <= {WIDTH{1'b0}};
            mul_control  <= {WCONTROL{1'b0}};
        end else begin
            tag_r        <= tag_s;
            inflight_r   <= inflight_s;
            fifo_count_r <= fifo_count_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            if (accept_s) begin
                mul_a       <= in_a;
                mul_b       <= in_b;
                mul_control <= in_control;
            end
        end
    end

    // Result storage; entries are only visible through the valid-gated head, so no reset.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            mem_r[wr_ptr_r] <= {mul_out, mul_flags};
        end
    end

endmodule

// File: tb/tb_fpmul_issue_ctrl.sv
// Directed bench for fpmul_issue_ctrl (LATENCY=2, DEPTH=4) with a behavioural
// two-stage registered multiplier wrapper.
module tb_fpmul_issue_ctrl;

    localparam int W  = 32;
    localparam int WC = 3;
    localparam int WF = 5;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          in_valid   = 1'b0;
    logic          res_ready  = 1'b0;
    logic [W-1:0]  in_a       = 32'h0;
    logic [W-1:0]  in_b       = 32'h0;
    logic [WC-1:0] in_control = 3'd0;
    logic          in_ready;
    logic          res_valid;
    logic          busy;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [WC-1:0] mul_control;
    logic [W-1:0]  mul_out;
    logic [WF-1:0] mul_flags;
    logic [W-1:0]  res_data;
    logic [WF-1:0] res_flags;

    // wrapper model: operand flops, multiplier, output flops
    logic [W-1:0]  w_a    = 32'h0;
    logic [W-1:0]  w_b    = 32'h0;
    logic [WC-1:0] w_c    = 3'd0;
    logic [W-1:0]  w_out  = 32'h0;
    logic [WF-1:0] w_flag = 5'd0;

    int checks   = 0;
    int failures = 0;
    int ovf_errs = 0;

    // operands and hand-computed products: 1*2, 1.5*2, 2*2, 3*0.5, 0.5*4, 1.25*2, -1*3, 4*0.25
    logic [31:0] va [0:7] = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000,
                              32'h3F000000, 32'h3FA00000, 32'hBF800000, 32'h40800000};
    logic [31:0] vb [0:7] = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h3F000000,
                              32'h40800000, 32'h40000000, 32'h40400000, 32'h3E800000};
    logic [31:0] vp [0:7] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h3FC00000,
                              32'h40000000, 32'h40200000, 32'hC0400000, 32'h3F800000};

    fpmul_issue_ctrl #(
        .WIDTH(W), .WCONTROL(WC), .WFLAG(WF), .LATENCY(2), .DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_control(in_control),
        .mul_a(mul_a), .mul_b(mul_b), .mul_control(mul_control),
        .mul_out(mul_out), .mul_flags(mul_flags),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // normal-only truncating single-precision multiply
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (m[47]) return {s, e[7:0] + 8'd1, m[46:24]};
        return {s, e[7:0], m[45:23]};
    endfunction

    always @(posedge clk) begin
        w_a    <= mul_a;
        w_b    <= mul_b;
        w_c    <= mul_control;
        w_out  <= fmul(w_a, w_b);
        w_flag <= {2'b00, w_c};
    end

    assign mul_out   = w_out;
    assign mul_flags = w_flag;

    // a capture must never find the FIFO already full
    always @(posedge clk) begin
        if (reset && dut.tag_r[2] && dut.fifo_count_r == 3'd4) begin
            ovf_errs++;
            $display("FAIL fifo_overflow: capture with fifo_count=%0d at %0t", dut.fifo_count_r, $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_a = 32'h12345678; in_b = 32'h3F800000; in_control = 3'd2;
        step();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
        #3 reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (mul_a !== 32'h0) begin failures++; $display("FAIL reset_mul_a: got %h want 0", mul_a); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (res_data !== 32'h0) begin failures++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        #2 reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'h40000000; in_control = 3'd0; res_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (mul_a !== 32'h3FC00000) begin failures++; $display("FAIL single_mul_a: got %h want 3fc00000", mul_a); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %b want 0 (edge t+%0d)", res_valid, k); end
            step();
        end
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", res_valid); end
        checks++; if (res_data !== 32'h40400000) begin failures++; $display("FAIL single_data: got %h want 40400000", res_data); end
        checks++; if (res_flags !== 5'd0) begin failures++; $display("FAIL single_flags: got %h want 00", res_flags); end
        step();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_popped: got %b want 0", res_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_q [$];
        logic [4:0]  expf_q [$];
        logic [2:0]  pipe;
        logic        acc, pop, cap;
        int          im, fm, nacc, got;
        pipe = 3'b000; im = 0; fm = 0; nacc = 0; got = 0;
        res_ready = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            in_valid   = (nacc < 8);
            in_a       = va[nacc % 8];
            in_b       = vb[nacc % 8];
            in_control = 3'(nacc % 8);
            checks++; if (in_ready !== ((im + fm) < 4)) begin failures++; $display("FAIL stream_in_ready c=%0d: got %b want %b", c, in_ready, ((im + fm) < 4)); end
            checks++; if (res_valid !== (fm > 0)) begin failures++; $display("FAIL stream_res_valid c=%0d: got %b want %b", c, res_valid, (fm > 0)); end
            acc = in_valid && in_ready;
            pop = res_valid && res_ready;
            if (pop) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL stream_extra_result: got %h want none", res_data);
                end else begin
                    if (res_data !== exp_q[0] || res_flags !== expf_q[0]) begin
                        failures++; $display("FAIL stream_data #%0d: got %h/%h want %h/%h", got, res_data, res_flags, exp_q[0], expf_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(expf_q.pop_front());
                end
                got++;
            end
            if (acc) begin
                exp_q.push_back(vp[nacc % 8]);
                expf_q.push_back({2'b00, 3'(nacc % 8)});
                nacc++;
            end
            cap  = pipe[2];
            pipe = {pipe[1:0], acc};
            im   = im + int'(acc) - int'(cap);
            fm   = fm + int'(cap) - int'(pop);
            step();
        end
        in_valid = 1'b0;
        checks++; if (got != 8) begin failures++; $display("FAIL stream_count: got %0d want 8", got); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stream_busy: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int nacc, got;
        nacc = 0; got = 0;
        res_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (nacc < 6); in_a = va[nacc]; in_b = vb[nacc]; in_control = 3'(nacc);
            checks++; if (in_ready !== (c < 4)) begin failures++; $display("FAIL bp_in_ready c=%0d: got %b want %b", c, in_ready, (c < 4)); end
            if (in_valid && in_ready) nacc++;
            step();
        end
        checks++; if (nacc != 4) begin failures++; $display("FAIL bp_accepted: got %0d want 4", nacc); end
        checks++; if (res_valid !== 1'b1 || res_data !== vp[0]) begin failures++; $display("FAIL bp_head: got %b/%h want 1/%h", res_valid, res_data, vp[0]); end
        res_ready = 1'b1;
        in_valid = 1'b1; in_a = va[nacc]; in_b = vb[nacc]; in_control = 3'(nacc);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        step();
        got = 1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_pop: got %b want 1", in_ready); end
        checks++; if (res_data !== vp[1]) begin failures++; $display("FAIL bp_second: got %h want %h", res_data, vp[1]); end
        for (int c = 0; c < 20 && got < 6; c++) begin
            in_valid = (nacc < 6); in_a = va[nacc % 8]; in_b = vb[nacc % 8]; in_control = 3'(nacc % 8);
            if (res_valid) begin
                checks++;
                if (got >= 6) begin
                    failures++; $display("FAIL bp_extra_result: got %h want none", res_data);
                end else if (res_data !== vp[got] || res_flags !== {2'b00, 3'(got)}) begin
                    failures++; $display("FAIL bp_data #%0d: got %h/%h want %h/%h", got, res_data, res_flags, vp[got], {2'b00, 3'(got)});
                end
                got++;
            end
            if (in_valid && in_ready) nacc++;
            step();
        end
        in_valid = 1'b0;
        checks++; if (got != 6 || nacc != 6) begin failures++; $display("FAIL bp_complete: got %0d/%0d want 6/6", got, nacc); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy: got %b want 0", busy); end
    endtask

    task automatic test_simultaneous();
        int nacc;
        nacc = 0;
        res_ready = 1'b0;
        // e0..e3: four accepts fill the credits
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_a = va[nacc]; in_b = vb[nacc]; in_control = 3'(nacc);
            if (in_ready) nacc++;
            step();
        end
        in_a = va[nacc]; in_b = vb[nacc]; in_control = 3'(nacc);
        checks++; if (nacc != 4 || in_ready !== 1'b0) begin failures++; $display("FAIL sim_fill: got %0d/%b want 4/0", nacc, in_ready); end
        step();
        step();
        checks++; if (dut.inflight_r + dut.fifo_count_r != 4 || dut.fifo_count_r != 3'd3) begin
            failures++; $display("FAIL sim_limit: got inflight=%0d fifo=%0d want 1/3", dut.inflight_r, dut.fifo_count_r); end
        // e6: capture op3 and pop op0 with the FIFO at DEPTH-1
        res_ready = 1'b1;
        step();
        checks++; if (dut.fifo_count_r !== 3'd3 || dut.inflight_r !== 3'd0) begin
            failures++; $display("FAIL sim_cap_pop_3: got inflight=%0d fifo=%0d want 0/3", dut.inflight_r, dut.fifo_count_r); end
        checks++; if (res_data !== vp[1] || in_ready !== 1'b1) begin failures++; $display("FAIL sim_head1: got %h/%b want %h/1", res_data, in_ready, vp[1]); end
        // e7, e8: accept and pop on the same edge
        for (int k = 0; k < 2; k++) begin
            if (in_ready) nacc++;
            step();
            in_a = va[nacc]; in_b = vb[nacc]; in_control = 3'(nacc);
            checks++; if (dut.inflight_r + dut.fifo_count_r != 3 || dut.inflight_r != k + 1) begin
                failures++; $display("FAIL sim_acc_pop%0d: got inflight=%0d fifo=%0d want %0d/%0d", k, dut.inflight_r, dut.fifo_count_r, k + 1, 2 - k); end
            checks++; if (res_data !== vp[2 + k]) begin failures++; $display("FAIL sim_head%0d: got %h want %h", 2 + k, res_data, vp[2 + k]); end
        end
        in_valid = 1'b0;
        res_ready = 1'b0;
        step();
        // e10, e11: capture and pop on the same edge with one entry buffered
        res_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (dut.fifo_count_r !== 3'd1 || res_data !== vp[4 + k] || res_flags !== {2'b00, 3'(4 + k)}) begin
                failures++; $display("FAIL sim_cap_pop_1 k=%0d: got fifo=%0d %h/%h want 1 %h/%h", k, dut.fifo_count_r, res_data, res_flags, vp[4 + k], {2'b00, 3'(4 + k)}); end
        end
        step();
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || nacc != 6) begin
            failures++; $display("FAIL sim_drain: got valid=%b busy=%b acc=%0d want 0/0/6", res_valid, busy, nacc); end
    endtask

    task automatic test_reset_midflight();
        res_ready = 1'b1;
        in_valid = 1'b1; in_a = va[0]; in_b = vb[0]; in_control = 3'd0;
        step();
        in_a = va[1]; in_b = vb[1]; in_control = 3'd1;
        step();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        #3 reset = 1'b0;
        #10 reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL mid_res_valid c=%0d: got %b want 0", c, res_valid); end
        end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mid_idle: got ready=%b busy=%b want 1/0", in_ready, busy); end
    endtask

    initial begin
        #12 reset = 1'b1;
        step();
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_reset_midflight();
        checks++; if (ovf_errs != 0) begin failures++; $display("FAIL overflow_monitor: got %0d want 0", ovf_errs); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
